// File: rtl/rx_sys.sv
// Sorted-frame checker: captures a frame on compare_en, scans it LANES elements per beat for order and checksum, reports a verdict.
// Latency: chk_done pulses 1+DATA_CNT/LANES edges after capture; no backpressure, strobes arriving while busy are dropped and counted.
// Build option RX_STICKY_ERR_EN makes order_err/sum_err/err_idx sticky until reset.
module rx_sys #(
  parameter int                 DATA_WIDTH = 64,
  parameter int                 DATA_CNT   = 1024,
  parameter string              COM_STYLE  = "UP",
  parameter int                 LANES      = 64,
  parameter int                 SUM_W      = DATA_WIDTH + $clog2(DATA_CNT),
  parameter logic [SUM_W-1:0]   EXP_SUM    = SUM_W'((64'(DATA_CNT) * 64'(DATA_CNT - 1)) / 64'd2)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        compare_en,
  input  logic [DATA_WIDTH-1:0]       compare_data [DATA_CNT],
  output logic                        busy,
  output logic                        chk_done,
  output logic                        chk_pass,
  output logic                        order_err,
  output logic                        sum_err,
  output logic [$clog2(DATA_CNT)-1:0] err_idx,
  output logic [15:0]                 frame_cnt,
  output logic [15:0]                 fail_cnt,
  output logic [15:0]                 ovr_cnt
);

  localparam int IDX_W  = $clog2(DATA_CNT);
  localparam int BEATS  = DATA_CNT / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam bit ASCEND = (COM_STYLE == "UP");

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t                  state, next_state;
  logic                    capture, scan, finish, drop;
  logic [DATA_WIDTH-1:0]   shadow [DATA_CNT];
  logic [BEAT_W-1:0]       beat;
  logic [SUM_W-1:0]        sum;
  logic                    ord_flag;
  logic [IDX_W-1:0]        first_idx;

  logic [SUM_W-1:0]        beat_sum;
  logic                    beat_viol;
  logic [IDX_W-1:0]        beat_idx;
  logic [IDX_W-1:0]        cur_i, nxt_i;
  logic                    sum_bad, frame_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    scan       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (compare_en) begin
        capture    = 1'b1;
        next_state = SCAN;
      end
      SCAN: begin
        scan = 1'b1;
        if (beat == LAST_BEAT) next_state = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign drop = compare_en && (state != IDLE);

  // Pairs may straddle a beat boundary; the whole shadow copy is visible so i+1 is always readable.
  always_comb begin
    beat_sum  = '0;
    beat_viol = 1'b0;
    beat_idx  = '0;
    cur_i     = '0;
    nxt_i     = '0;
    for (int j = 0; j < LANES; j++) begin
      cur_i    = IDX_W'(int'(beat) * LANES + j);
      beat_sum = beat_sum + SUM_W'(shadow[cur_i]);
      if (int'(beat) * LANES + j + 1 < DATA_CNT) begin
        nxt_i = cur_i + IDX_W'(1);
        if (!beat_viol && (ASCEND ? (shadow[cur_i] > shadow[nxt_i])
                                  : (shadow[cur_i] < shadow[nxt_i]))) begin
          beat_viol = 1'b1;
          beat_idx  = cur_i;
        end
      end
    end
  end

  assign sum_bad    = (sum != EXP_SUM);
  assign frame_fail = ord_flag || sum_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DATA_CNT; n++) shadow[n] <= '0;
      beat      <= '0;
      sum       <= '0;
      ord_flag  <= 1'b0;
      first_idx <= '0;
      busy      <= 1'b0;
      chk_done  <= 1'b0;
      chk_pass  <= 1'b0;
      order_err <= 1'b0;
      sum_err   <= 1'b0;
      err_idx   <= '0;
      frame_cnt <= '0;
      fail_cnt  <= '0;
      ovr_cnt   <= '0;
    end else begin
      chk_done <= 1'b0;
      if (drop && ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;

      if (capture) begin
        shadow    <= compare_data;
        beat      <= '0;
        sum       <= '0;
        ord_flag  <= 1'b0;
        first_idx <= '0;
        busy      <= 1'b1;
      end

      if (scan) begin
        sum  <= sum + beat_sum;
        beat <= beat + BEAT_W'(1);
        if (beat_viol && !ord_flag) begin
          ord_flag  <= 1'b1;
          first_idx <= beat_idx;
        end
      end

      if (finish) begin
        chk_done <= 1'b1;
        chk_pass <= !frame_fail;
        busy     <= 1'b0;
`ifdef RX_STICKY_ERR_EN
        order_err <= order_err | ord_flag;
        sum_err   <= sum_err | sum_bad;
        if (ord_flag && !order_err) err_idx <= first_idx;
`else
        order_err <= ord_flag;
        sum_err   <= sum_bad;
        err_idx   <= ord_flag ? first_idx : '0;
`endif
        if (frame_cnt != 16'hFFFF)              frame_cnt <= frame_cnt + 16'd1;
        if (frame_fail && fail_cnt != 16'hFFFF) fail_cnt  <= fail_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rx_sys.sv
// Directed bench for rx_sys: table of frame patterns with hand-derived verdicts, plus overrun and reset-mid-scan sequences.
module tb_rx_sys;

`ifdef RX_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk, rst_n, en_up, en_dn, sel;
  logic [63:0] frame [1024];

  logic        up_busy, up_done, up_pass, up_oe, up_se;
  logic [9:0]  up_idx;
  logic [15:0] up_fc, up_flc, up_ovr;
  logic        dn_busy, dn_done, dn_pass, dn_oe, dn_se;
  logic [9:0]  dn_idx;
  logic [15:0] dn_fc, dn_flc, dn_ovr;

  logic        o_busy, o_done, o_pass, o_oe, o_se;
  logic [9:0]  o_idx;
  logic [15:0] o_fc, o_flc, o_ovr;

  int errors = 0;
  int checks = 0;

  rx_sys u_up (
    .clk(clk), .rst_n(rst_n), .compare_en(en_up), .compare_data(frame),
    .busy(up_busy), .chk_done(up_done), .chk_pass(up_pass), .order_err(up_oe),
    .sum_err(up_se), .err_idx(up_idx), .frame_cnt(up_fc), .fail_cnt(up_flc), .ovr_cnt(up_ovr)
  );

  rx_sys #(.COM_STYLE("DOWN")) u_dn (
    .clk(clk), .rst_n(rst_n), .compare_en(en_dn), .compare_data(frame),
    .busy(dn_busy), .chk_done(dn_done), .chk_pass(dn_pass), .order_err(dn_oe),
    .sum_err(dn_se), .err_idx(dn_idx), .frame_cnt(dn_fc), .fail_cnt(dn_flc), .ovr_cnt(dn_ovr)
  );

  assign o_busy = sel ? dn_busy : up_busy;
  assign o_done = sel ? dn_done : up_done;
  assign o_pass = sel ? dn_pass : up_pass;
  assign o_oe   = sel ? dn_oe   : up_oe;
  assign o_se   = sel ? dn_se   : up_se;
  assign o_idx  = sel ? dn_idx  : up_idx;
  assign o_fc   = sel ? dn_fc   : up_fc;
  assign o_flc  = sel ? dn_flc  : up_flc;
  assign o_ovr  = sel ? dn_ovr  : up_ovr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // kind: 0 ascending, 1 descending, 2 ascending with swaps at p (and q if q>=0),
  //       3 ascending with d[p]=q, 4 descending with swap at p
  task automatic build(input int kind, input int p, input int q);
    logic [63:0] tmp;
    for (int i = 0; i < 1024; i++)
      frame[i] = (kind == 1 || kind == 4) ? 64'(1023 - i) : 64'(i);
    if (kind == 2 || kind == 4) begin
      tmp = frame[p]; frame[p] = frame[p+1]; frame[p+1] = tmp;
    end
    if (kind == 2 && q >= 0) begin
      tmp = frame[q]; frame[q] = frame[q+1]; frame[q+1] = tmp;
    end
    if (kind == 3) frame[p] = 64'(q);
  endtask

  int done_seen;
  task automatic tick();
    @(negedge clk);
    if (up_done) done_seen++;
  endtask

  typedef struct {
    int d; int kind; int p; int q;
    bit pass; bit oe; bit se; int idx;
  } vec_t;

  function automatic vec_t mk(int d, int kind, int p, int q, bit pass, bit oe, bit se, int idx);
    vec_t v;
    v.d = d; v.kind = kind; v.p = p; v.q = q;
    v.pass = pass; v.oe = oe; v.se = se; v.idx = idx;
    return v;
  endfunction

  vec_t vecs [14];
  int   m_fc [2], m_flc [2], m_idx [2];
  bit   m_oe [2], m_se [2];

  initial begin
    int lat;
    rst_n = 1'b0; en_up = 1'b0; en_dn = 1'b0; sel = 1'b0;
    build(0, 0, -1);
    repeat (3) @(negedge clk);

    chk("rst_busy", up_busy, 0);
    chk("rst_done", up_done, 0);
    chk("rst_pass", up_pass, 0);
    chk("rst_counts", {up_fc, up_flc, up_ovr}, 0);
    chk("rst_dn_flags", {dn_busy, dn_done, dn_pass, dn_oe, dn_se, dn_idx}, 0);
    rst_n = 1'b1;

    vecs[0]  = mk(0, 0,    0, -1,   1, 0, 0, 0);
    vecs[1]  = mk(0, 2,  300, -1,   0, 1, 0, 300);
    vecs[2]  = mk(0, 3, 1023, 1024, 0, 0, 1, 0);
    vecs[3]  = mk(0, 0,    0, -1,   1, 0, 0, 0);
    vecs[4]  = mk(1, 1,    0, -1,   1, 0, 0, 0);
    vecs[5]  = mk(1, 0,    0, -1,   0, 1, 0, 0);
    vecs[6]  = mk(0, 1,    0, -1,   0, 1, 0, 0);
    vecs[7]  = mk(0, 3,    5, 7,    0, 1, 1, 5);
    vecs[8]  = mk(0, 2, 1022, -1,   0, 1, 0, 1022);
    vecs[9]  = mk(0, 3,   64, 63,   0, 0, 1, 0);
    vecs[10] = mk(0, 2,   63, -1,   0, 1, 0, 63);
    vecs[11] = mk(1, 4,  500, -1,   0, 1, 0, 500);
    vecs[12] = mk(0, 2,  100, 900,  0, 1, 0, 100);
    vecs[13] = mk(0, 0,    0, -1,   1, 0, 0, 0);

    for (int d = 0; d < 2; d++) begin
      m_fc[d] = 0; m_flc[d] = 0; m_oe[d] = 0; m_se[d] = 0; m_idx[d] = 0;
    end

    for (int v = 0; v < 14; v++) begin
      int d;
      d = vecs[v].d;
      build(vecs[v].kind, vecs[v].p, vecs[v].q);
      sel = (d != 0);
      @(negedge clk);
      if (d == 0) en_up = 1'b1; else en_dn = 1'b1;
      @(negedge clk);
      en_up = 1'b0; en_dn = 1'b0;
      chk($sformatf("v%0d_busy_after_capture", v), o_busy, 1);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (o_done) begin
          lat = n;
          break;
        end
      end

      m_fc[d]++;
      if (!vecs[v].pass) m_flc[d]++;
      if (STICKY) begin
        if (vecs[v].oe && !m_oe[d]) m_idx[d] = vecs[v].idx;
        m_oe[d] = m_oe[d] | vecs[v].oe;
        m_se[d] = m_se[d] | vecs[v].se;
      end else begin
        m_oe[d]  = vecs[v].oe;
        m_se[d]  = vecs[v].se;
        m_idx[d] = vecs[v].idx;
      end

      chk($sformatf("v%0d_latency", v), lat, 17);
      chk($sformatf("v%0d_chk_pass", v), o_pass, vecs[v].pass);
      chk($sformatf("v%0d_order_err", v), o_oe, m_oe[d]);
      chk($sformatf("v%0d_sum_err", v), o_se, m_se[d]);
      chk($sformatf("v%0d_err_idx", v), o_idx, m_idx[d]);
      chk($sformatf("v%0d_frame_cnt", v), o_fc, m_fc[d]);
      chk($sformatf("v%0d_fail_cnt", v), o_flc, m_flc[d]);
      chk($sformatf("v%0d_ovr_cnt", v), o_ovr, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse_width", v), o_done, 0);
      chk($sformatf("v%0d_busy_cleared", v), o_busy, 0);
      chk($sformatf("v%0d_pass_held", v), o_pass, vecs[v].pass);
    end

    // Overrun: strobes every 16 cycles, only the 1st and 3rd fit
    sel = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    build(0, 0, -1);
    done_seen = 0;
    for (int s = 0; s < 4; s++) begin
      en_up = 1'b1;
      tick();
      en_up = 1'b0;
      repeat (15) tick();
    end
    repeat (40) tick();
    chk("ovr16_verdicts", done_seen, 2);
    chk("ovr16_ovr_cnt", up_ovr, 2);
    chk("ovr16_frame_cnt", up_fc, 2);
    chk("ovr16_fail_cnt", up_flc, 0);

    // 32-cycle spacing: every strobe accepted
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int s = 0; s < 4; s++) begin
      en_up = 1'b1;
      tick();
      en_up = 1'b0;
      repeat (31) tick();
    end
    repeat (40) tick();
    chk("ovr32_verdicts", done_seen, 4);
    chk("ovr32_ovr_cnt", up_ovr, 0);
    chk("ovr32_frame_cnt", up_fc, 4);
    chk("ovr32_chk_pass", up_pass, 1);

    // Reset during beat 8 of a failing frame
    build(2, 300, -1);
    done_seen = 0;
    en_up = 1'b1;
    tick();
    en_up = 1'b0;
    repeat (8) tick();
    chk("midscan_busy_before_reset", up_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midscan_rst_busy", up_busy, 0);
    chk("midscan_rst_flags", {up_done, up_pass, up_oe, up_se}, 0);
    chk("midscan_rst_idx", up_idx, 0);
    chk("midscan_rst_frame_cnt", up_fc, 0);
    chk("midscan_rst_fail_cnt", up_flc, 0);
    chk("midscan_rst_ovr_cnt", up_ovr, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("midscan_no_verdict", done_seen, 0);
    chk("midscan_frame_cnt_after", up_fc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
